// File: rtl/pc_unit.sv
// Fetch-stage program counter: boot/run/halt control, redirect, trap entry/return
// with saved exception PC, and an optional wrap window on sequential increments.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter bit              WRAP_EN      = 1'b1,
  parameter logic [XLEN-1:0] WRAP_LIMIT   = XLEN'(32'h0000_0023),
  parameter logic [XLEN-1:0] WRAP_TARGET  = XLEN'(32'h0000_000C)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_i,
  input  logic            mret_i,
  input  logic            halt_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] epc_o,
  output logic            misalign_o
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] epc_q;
  logic            pc_valid_q;
  logic            misalign_q;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] seq_next;
  logic            target_misaligned;

  assign pc_plus4          = pc_q + XLEN'(4);
  assign target_misaligned = |redirect_target_i[1:0];

  // Wrap only ever applies to the sequential path.
  always_comb begin
    seq_next = pc_plus4;
    if (WRAP_EN && (pc_plus4 > WRAP_LIMIT)) begin
      seq_next = WRAP_TARGET;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      unique case (state_q)
        StBoot: begin
          state_q    <= StRun;
          pc_valid_q <= 1'b1;
        end
        StRun: begin
          if (trap_i) begin
            pc_q  <= TRAP_VECTOR;
            epc_q <= pc_q;
          end else if (mret_i) begin
            pc_q <= epc_q;
          end else if (redirect_i && target_misaligned) begin
            pc_q       <= TRAP_VECTOR;
            epc_q      <= redirect_target_i;
            misalign_q <= 1'b1;
          end else if (redirect_i) begin
            pc_q <= redirect_target_i;
          end else if (halt_i) begin
            state_q    <= StHalt;
            pc_valid_q <= 1'b0;
          end else if (!stall_i) begin
            pc_q <= seq_next;
          end
        end
        StHalt: begin
          // Only a trap or an aligned redirect wakes the unit; a misaligned one is dropped.
          if (trap_i) begin
            state_q    <= StRun;
            pc_valid_q <= 1'b1;
            pc_q       <= TRAP_VECTOR;
            epc_q      <= pc_q;
          end else if (redirect_i && !target_misaligned) begin
            state_q    <= StRun;
            pc_valid_q <= 1'b1;
            pc_q       <= redirect_target_i;
          end
        end
        default: begin
          state_q    <= StBoot;
          pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4;
  assign pc_valid_o = pc_valid_q;
  assign epc_o      = epc_q;
  assign misalign_o = misalign_q;

endmodule
